// File: rtl/stream_packer_256.sv
// Packs eight 32-bit event words into one 256-bit stream word for the GPIF writer,
// with flush/timeout padding, drop accounting and an incrementing test-pattern source.
module stream_packer_256 #(
    parameter int unsigned TIMEOUT   = 50000,
    parameter logic [31:0] FILL_WORD = 32'hFFFF_FFFF,
    parameter int unsigned DROP_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       word_i,
    input  logic              word_valid_i,
    input  logic              flush_i,
    input  logic              test_mode_i,
    input  logic              stream_full_i,
    input  logic              stream_prog_full_i,
    output logic [255:0]      stream_data_o,
    output logic              stream_write_o,
    output logic [DROP_W-1:0] drop_count_o,
    output logic              overflow_o,
    output logic              busy_o
);
    localparam int LANES = 8;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {FILL, WAIT, PAD} state_t;

    state_t                 state;
    logic [LANES-1:0][31:0] acc, acc_n;
    logic [2:0]             lane;
    logic [255:0]           hold;
    logic                   hold_valid;
    logic [31:0]            tcnt;
    logic [TW-1:0]          idle;

    logic        src_valid, accept, drop, hold_free, last_lane, timeout_hit, go_pad, load;
    logic [31:0] src_data;

    assign src_valid   = test_mode_i ? ~stream_prog_full_i : word_valid_i;
    assign src_data    = test_mode_i ? tcnt : word_i;
    assign accept      = (state == FILL) && src_valid;
    assign drop        = (state != FILL) && src_valid;
    assign hold_free   = ~hold_valid | ~stream_full_i;
    assign last_lane   = accept && (lane == 3'd7);
    assign timeout_hit = (TIMEOUT != 0) && (idle == TW'(TIMEOUT));
    // A flush coinciding with a word is deferred to a PAD cycle unless that word closes the packet.
    assign go_pad      = (state == FILL) && !last_lane && ((lane != 3'd0) || accept) &&
                         (flush_i || (!accept && timeout_hit));
    assign load        = (last_lane || state == PAD || state == WAIT) && hold_free;

    assign stream_data_o  = hold;
    assign stream_write_o = hold_valid & ~stream_full_i;
    assign busy_o         = (lane != 3'd0) | hold_valid | (state != FILL);

    always_comb begin
        acc_n = acc;
        if (accept)
            acc_n[lane] = src_data;
        if (state == PAD) begin
            for (int i = 0; i < LANES; i++)
                if (3'(i) >= lane)
                    acc_n[i] = FILL_WORD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            acc          <= '0;
            lane         <= '0;
            hold         <= '0;
            hold_valid   <= 1'b0;
            tcnt         <= '0;
            idle         <= '0;
            drop_count_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        acc  <= acc_n;
                        lane <= lane + 3'd1;
                        if (test_mode_i)
                            tcnt <= tcnt + 32'd1;
                    end
                    if (last_lane && !hold_free)
                        state <= WAIT;
                    else if (go_pad)
                        state <= PAD;
                end
                PAD: begin
                    acc   <= acc_n;
                    lane  <= '0;
                    state <= hold_free ? FILL : WAIT;
                end
                WAIT: begin
                    if (hold_free)
                        state <= FILL;
                end
                default: state <= FILL;
            endcase

            if (load) begin
                hold       <= acc_n;
                hold_valid <= 1'b1;
            end else if (stream_write_o) begin
                hold_valid <= 1'b0;
            end

            if (state == FILL && lane != 3'd0 && !accept)
                idle <= timeout_hit ? idle : idle + TW'(1);
            else
                idle <= '0;

            if (drop) begin
                overflow_o <= 1'b1;
                if (~&drop_count_o)
                    drop_count_o <= drop_count_o + DROP_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_stream_packer_256.sv
// Directed bench for stream_packer_256: stimulus pushes expected packets to a
// scoreboard queue, a negedge monitor pops and compares on every write strobe.
module tb_stream_packer_256;
    localparam int          TO   = 100;
    localparam logic [31:0] FILL = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  word_i = '0;
    logic         word_valid_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         test_mode_i = 1'b0;
    logic         stream_full_i = 1'b0;
    logic         stream_prog_full_i = 1'b0;
    logic [255:0] stream_data_o;
    logic         stream_write_o;
    logic [31:0]  drop_count_o;
    logic         overflow_o;
    logic         busy_o;

    stream_packer_256 #(.TIMEOUT(TO), .FILL_WORD(FILL), .DROP_W(32)) dut (
        .clk(clk), .rst(rst), .word_i(word_i), .word_valid_i(word_valid_i),
        .flush_i(flush_i), .test_mode_i(test_mode_i), .stream_full_i(stream_full_i),
        .stream_prog_full_i(stream_prog_full_i), .stream_data_o(stream_data_o),
        .stream_write_o(stream_write_o), .drop_count_o(drop_count_o),
        .overflow_o(overflow_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    int           wr_cnt = 0;
    logic [255:0] sb[$];
    logic [255:0] pkt = '0;
    int           nlanes = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference packer: shift each word in from the top so lane 0 ends at bits [31:0].
    task automatic add(input logic [31:0] w);
        pkt = {w, pkt[255:32]};
        nlanes++;
        if (nlanes == 8) begin
            sb.push_back(pkt);
            nlanes = 0;
        end
    endtask

    task automatic pad();
        while (nlanes != 0) add(FILL);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        word_i = w;
        word_valid_i = 1'b1;
        tick();
        word_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && stream_write_o) begin
            wr_cnt++;
            chk("sb_has_entry", 256'(sb.size() != 0), 256'd1);
            if (sb.size() != 0)
                chk("stream_data", stream_data_o, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, tw, guard;
        logic [31:0] tc;

        // reset values
        @(negedge clk);
        chk("rst_data", stream_data_o, '0);
        chk("rst_write", 256'(stream_write_o), 256'd0);
        chk("rst_drop", 256'(drop_count_o), 256'd0);
        chk("rst_ovf", 256'(overflow_o), 256'd0);
        chk("rst_busy", 256'(busy_o), 256'd0);
        tick();
        rst = 1'b0;
        tick();

        // eight consecutive words, write strobe one cycle later
        for (int i = 1; i <= 8; i++) begin
            add(32'(i));
            send(32'(i));
        end
        @(negedge clk);
        chk("latency_write", 256'(stream_write_o), 256'd1);
        @(negedge clk);
        chk("single_pulse", 256'(stream_write_o), 256'd0);
        tick();

        // explicit flush after three words
        w0 = wr_cnt;
        add(32'hA); send(32'hA);
        add(32'hB); send(32'hB);
        add(32'hC); send(32'hC);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        pad();
        repeat (4) tick();
        chk("flush_write_count", 256'(wr_cnt), 256'(w0 + 1));

        // idle timeout after five words
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            add(32'h100 + 32'(i));
            send(32'h100 + 32'(i));
        end
        chk("busy_partial", 256'(busy_o), 256'd1);
        pad();
        repeat (TO) tick();
        chk("no_early_timeout", 256'(wr_cnt), 256'(w0));
        repeat (10) tick();
        chk("timeout_write", 256'(wr_cnt), 256'(w0 + 1));

        // writer full: 8 to hold, 8 to accumulator, 4 dropped
        stream_full_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) add(32'h200 + 32'(i));
            send(32'h200 + 32'(i));
        end
        chk("drop_count", 256'(drop_count_o), 256'd4);
        chk("overflow", 256'(overflow_o), 256'd1);
        @(negedge clk);
        chk("full_blocks_write", 256'(stream_write_o), 256'd0);
        chk("busy_full", 256'(busy_o), 256'd1);
        tick();
        stream_full_i = 1'b0;
        @(negedge clk);
        chk("release_write1", 256'(stream_write_o), 256'd1);
        @(negedge clk);
        chk("release_write2", 256'(stream_write_o), 256'd1);
        @(negedge clk);
        chk("release_end", 256'(stream_write_o), 256'd0);
        tick();
        chk("busy_drained", 256'(busy_o), 256'd0);

        // test pattern with prog_full toggling
        w0 = wr_cnt;
        tc = '0;
        tw = 0;
        guard = 0;
        test_mode_i = 1'b1;
        while (tw < 32 && guard < 1000) begin
            stream_prog_full_i = 1'($urandom_range(0, 1));
            if (!stream_prog_full_i) begin
                add(tc);
                tc++;
                tw++;
            end
            tick();
            guard++;
        end
        test_mode_i = 1'b0;
        stream_prog_full_i = 1'b0;
        chk("test_words_generated", 256'(tw), 256'd32);
        repeat (5) tick();
        chk("test_write_count", 256'(wr_cnt), 256'(w0 + 4));
        chk("test_no_drop", 256'(drop_count_o), 256'd4);

        // reset mid-packet with hold valid
        stream_full_i = 1'b1;
        for (int i = 0; i < 12; i++) send(32'h300 + 32'(i));
        rst = 1'b1;
        #1;
        chk("midrst_data", stream_data_o, '0);
        chk("midrst_write", 256'(stream_write_o), 256'd0);
        chk("midrst_drop", 256'(drop_count_o), 256'd0);
        chk("midrst_ovf", 256'(overflow_o), 256'd0);
        chk("midrst_busy", 256'(busy_o), 256'd0);
        tick();
        stream_full_i = 1'b0;
        tick();
        rst = 1'b0;
        w0 = wr_cnt;
        repeat (5) tick();
        chk("no_write_after_rst", 256'(wr_cnt), 256'(w0));
        for (int i = 0; i < 8; i++) begin
            add(32'h400 + 32'(i));
            send(32'h400 + 32'(i));
        end
        repeat (3) tick();
        chk("post_rst_write", 256'(wr_cnt), 256'(w0 + 1));

        chk("sb_empty", 256'(sb.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
